// File: rtl/bsg_link_sdr_upstream_ctrl.sv
// Upstream SDR link sequencer: PHY reset, clock-only training, then credit-gated beats; 1-cycle data/token latency.
// Backpressure: core_ready_o drops combinationally when credits hit 0 or link_enable_i falls.
module bsg_link_sdr_upstream_ctrl #(
  parameter int width_p             = 16,
  parameter int max_credits_p       = 16,
  parameter int credit_decimation_p = 4,
  parameter int phy_reset_cycles_p  = 8,
  parameter int train_cycles_p      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 link_enable_i,
  input  logic                                 core_v_i,
  input  logic [width_p-1:0]                   core_data_i,
  output logic                                 core_ready_o,
  input  logic                                 token_i,
  output logic                                 phy_reset_o,
  output logic                                 phy_v_o,
  output logic [width_p-1:0]                   phy_data_o,
  output logic                                 link_up_o,
  output logic [$clog2(max_credits_p+1)-1:0]   credits_o,
  output logic                                 error_o
);

  localparam int credit_w_lp = $clog2(max_credits_p + 1);
  localparam int cnt_max_lp  = (phy_reset_cycles_p > train_cycles_p) ? phy_reset_cycles_p
                                                                      : train_cycles_p;
  localparam int cnt_w_lp    = $clog2(cnt_max_lp + 1);

  localparam logic [credit_w_lp-1:0] max_credits_lp  = credit_w_lp'(max_credits_p);
  localparam logic [credit_w_lp:0]   max_ext_lp      = (credit_w_lp + 1)'(max_credits_p);
  localparam logic [credit_w_lp:0]   decimation_lp   = (credit_w_lp + 1)'(credit_decimation_p);
  localparam logic [cnt_w_lp-1:0]    phy_reset_ld_lp = cnt_w_lp'(phy_reset_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0]    train_ld_lp     = cnt_w_lp'(train_cycles_p - 1);

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    PHY_RESET = 2'd1,
    TRAIN     = 2'd2,
    ACTIVE    = 2'd3
  } state_e;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [cnt_w_lp-1:0]      r_cnt;
  logic [cnt_w_lp-1:0]      w_cnt_nxt;
  logic [credit_w_lp-1:0]   r_credits;
  logic [credit_w_lp-1:0]   w_credits_nxt;
  logic                     r_error;
  logic                     w_error_nxt;
  logic                     r_phy_reset;
  logic                     r_phy_v;
  logic [width_p-1:0]       r_phy_data;
  logic                     r_link_up;

  logic                     w_core_ready;
  logic                     w_hs;
  logic [credit_w_lp:0]     w_hs_ext;
  logic [credit_w_lp:0]     w_token_ext;
  logic [credit_w_lp:0]     w_credit_sum;

  // Ready never looks at core_v_i, so the core may wait on it without a comb loop.
  assign w_core_ready = link_enable_i & (r_state == ACTIVE) & (r_credits != '0);
  assign w_hs         = core_v_i & w_core_ready;

  assign w_hs_ext     = {{credit_w_lp{1'b0}}, w_hs};
  assign w_token_ext  = token_i ? decimation_lp : '0;
  // One bit wider so a token arriving at full credit is seen as overflow, not wrap.
  assign w_credit_sum = {1'b0, r_credits} - w_hs_ext + w_token_ext;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_credits_nxt = r_credits;
    w_error_nxt   = r_error;

    if (!link_enable_i) begin
      w_state_nxt   = DISABLED;
      w_credits_nxt = max_credits_lp;
    end else begin
      case (r_state)
        DISABLED: begin
          w_state_nxt   = PHY_RESET;
          w_cnt_nxt     = phy_reset_ld_lp;
          w_credits_nxt = max_credits_lp;
        end
        PHY_RESET: begin
          w_credits_nxt = max_credits_lp;
          if (r_cnt == '0) begin
            w_state_nxt = TRAIN;
            w_cnt_nxt   = train_ld_lp;
          end else begin
            w_cnt_nxt   = r_cnt - 1'b1;
          end
        end
        TRAIN: begin
          w_credits_nxt = max_credits_lp;
          if (r_cnt == '0) begin
            w_state_nxt = ACTIVE;
          end else begin
            w_cnt_nxt   = r_cnt - 1'b1;
          end
        end
        ACTIVE: begin
          if (w_credit_sum > max_ext_lp) begin
            w_credits_nxt = max_credits_lp;
            w_error_nxt   = 1'b1;
          end else begin
            w_credits_nxt = w_credit_sum[credit_w_lp-1:0];
          end
        end
        default: begin
          w_state_nxt   = DISABLED;
          w_credits_nxt = max_credits_lp;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= DISABLED;
      r_cnt       <= '0;
      r_credits   <= max_credits_lp;
      r_error     <= 1'b0;
      r_phy_reset <= 1'b1;
      r_phy_v     <= 1'b0;
      r_phy_data  <= '0;
      r_link_up   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_credits   <= w_credits_nxt;
      r_error     <= w_error_nxt;
      r_phy_reset <= (w_state_nxt == DISABLED) || (w_state_nxt == PHY_RESET);
      r_link_up   <= (w_state_nxt == ACTIVE);
      r_phy_v     <= w_hs;
      if (w_hs) begin
        r_phy_data <= core_data_i;
      end
    end
  end

  assign core_ready_o = w_core_ready;
  assign phy_reset_o  = r_phy_reset;
  assign phy_v_o      = r_phy_v;
  assign phy_data_o   = r_phy_data;
  assign link_up_o    = r_link_up;
  assign credits_o    = r_credits;
  assign error_o      = r_error;

endmodule
